// File: rtl/wb_console_seq.sv
// Wishbone master that turns a byte stream into terminal-style updates of the
// wb_char_ram slave: char/control sequencing, shadow cursor and full-screen scroll.
module wb_console_seq #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 30,
  parameter logic [7:0]  BASE = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_i,
  input  logic       char_valid_i,
  output logic       char_ready_o,
  output logic [7:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  input  logic       wb_ack_i,
  output logic [6:0] cur_x_o,
  output logic [4:0] cur_y_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_BUS, S_SCR_RD, S_SCR_WR, S_SCR_FILL
  } state_t;

  localparam logic [6:0]  X_LAST    = 7'(COLS - 1);
  localparam logic [4:0]  Y_LAST    = 5'(ROWS - 1);
  localparam logic [11:0] IDX_FIRST = 12'(COLS);
  localparam logic [11:0] IDX_LAST  = 12'(COLS * ROWS - 1);
  localparam logic [11:0] FILL_PTR  = 12'((ROWS - 1) * COLS);
  localparam logic [7:0]  FILL_END  = 8'(COLS + 2);

  state_t      state, state_n, ret_state;
  logic [7:0]  ch, step, rd_data;
  logic [6:0]  x, pend_x;
  logic [4:0]  y;
  logic [11:0] idx, dst;
  logic        printable;

  logic        issue, iss_we, fin, to_scroll;
  logic [7:0]  iss_adr, iss_dat;
  logic [6:0]  fin_x, scr_x;
  logic [4:0]  fin_y;

  assign printable    = (ch >= 8'h20) && (ch <= 8'h7E);
  assign dst          = idx - IDX_FIRST;
  assign char_ready_o = (state == S_IDLE);
  assign busy_o       = (state != S_IDLE);
  assign cur_x_o      = x;
  assign cur_y_o      = y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (char_valid_i) state_n = S_DECODE;
      S_DECODE: begin
        if (issue)          state_n = S_BUS;
        else if (to_scroll) state_n = S_SCR_RD;
        else if (fin)       state_n = S_IDLE;
      end
      S_BUS:      if (wb_ack_i) state_n = ret_state;
      S_SCR_RD:   state_n = issue ? S_BUS : S_SCR_WR;
      S_SCR_WR: begin
        if (issue)                 state_n = S_BUS;
        else if (idx == IDX_LAST)  state_n = S_SCR_FILL;
        else                       state_n = S_SCR_RD;
      end
      S_SCR_FILL: state_n = issue ? S_BUS : S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Each sequencing state walks `step`; a step below the phase length issues one
  // transaction (BUS returns here with step+1), the step after it ends the phase.
  always_comb begin
    issue     = 1'b0;
    iss_adr   = '0;
    iss_dat   = '0;
    iss_we    = 1'b1;
    fin       = 1'b0;
    fin_x     = x;
    fin_y     = y;
    to_scroll = 1'b0;
    scr_x     = x;
    case (state)
      S_DECODE: begin
        if (printable) begin
          if (step < 8'd3) begin
            issue = 1'b1;
            case (step[1:0])
              2'd0:    begin iss_adr = BASE + 8'd1; iss_dat = {1'b0, x}; end
              2'd1:    begin iss_adr = BASE + 8'd2; iss_dat = {3'b0, y}; end
              default: begin iss_adr = BASE + 8'd4; iss_dat = ch; end
            endcase
          end else if (x != X_LAST) begin
            fin   = 1'b1;
            fin_x = 7'(x + 7'd1);
          end else if (y != Y_LAST) begin
            fin   = 1'b1;
            fin_x = '0;
            fin_y = 5'(y + 5'd1);
          end else begin
            to_scroll = 1'b1;
            scr_x     = '0;
          end
        end else begin
          case (ch)
            8'h0D: begin fin = 1'b1; fin_x = '0; end
            8'h0A: begin
              if (y != Y_LAST) begin fin = 1'b1; fin_y = 5'(y + 5'd1); end
              else             to_scroll = 1'b1;
            end
            8'h08: begin
              if (x == '0) fin = 1'b1;
              else if (step < 8'd3) begin
                issue = 1'b1;
                case (step[1:0])
                  2'd0:    begin iss_adr = BASE + 8'd1; iss_dat = {1'b0, 7'(x - 7'd1)}; end
                  2'd1:    begin iss_adr = BASE + 8'd2; iss_dat = {3'b0, y}; end
                  default: begin iss_adr = BASE + 8'd4; iss_dat = 8'h20; end
                endcase
              end else begin
                fin   = 1'b1;
                fin_x = 7'(x - 7'd1);
              end
            end
            8'h0C: begin
              if (step == 8'd0) begin issue = 1'b1; iss_adr = BASE; iss_dat = 8'h01; end
              else begin fin = 1'b1; fin_x = '0; fin_y = '0; end
            end
            default: fin = 1'b1;
          endcase
        end
      end
      S_SCR_RD: begin
        if (step < 8'd3) begin
          issue = 1'b1;
          case (step[1:0])
            2'd0:    begin iss_adr = BASE + 8'd6; iss_dat = {4'b0, idx[11:8]}; end
            2'd1:    begin iss_adr = BASE + 8'd7; iss_dat = idx[7:0]; end
            default: begin iss_adr = BASE + 8'd8; iss_we = 1'b0; end
          endcase
        end
      end
      S_SCR_WR: begin
        if (step < 8'd3) begin
          issue = 1'b1;
          case (step[1:0])
            2'd0:    begin iss_adr = BASE + 8'd6; iss_dat = {4'b0, dst[11:8]}; end
            2'd1:    begin iss_adr = BASE + 8'd7; iss_dat = dst[7:0]; end
            default: begin iss_adr = BASE + 8'd8; iss_dat = rd_data; end
          endcase
        end
      end
      S_SCR_FILL: begin
        if (step == 8'd0) begin
          issue = 1'b1; iss_adr = BASE + 8'd6; iss_dat = {4'b0, FILL_PTR[11:8]};
        end else if (step == 8'd1) begin
          issue = 1'b1; iss_adr = BASE + 8'd7; iss_dat = FILL_PTR[7:0];
        end else if (step < FILL_END) begin
          issue = 1'b1; iss_adr = BASE + 8'd8; iss_dat = 8'h20;
        end else begin
          fin   = 1'b1;
          fin_x = pend_x;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      ret_state <= S_IDLE;
      ch        <= '0;
      step      <= '0;
      rd_data   <= '0;
      x         <= '0;
      y         <= '0;
      pend_x    <= '0;
      idx       <= '0;
    end else begin
      if (state == S_IDLE && char_valid_i) begin
        ch   <= char_i;
        step <= '0;
      end
      if (issue) begin
        wb_cyc_o  <= 1'b1;
        wb_stb_o  <= 1'b1;
        wb_we_o   <= iss_we;
        wb_adr_o  <= iss_adr;
        wb_dat_o  <= iss_dat;
        ret_state <= state;
      end
      if (state == S_BUS && wb_ack_i) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
        if (!wb_we_o) rd_data <= wb_dat_i;
        step <= 8'(step + 8'd1);
      end
      if (fin) begin
        x <= fin_x;
        y <= fin_y;
      end
      if (to_scroll) begin
        pend_x <= scr_x;
        idx    <= IDX_FIRST;
        step   <= '0;
      end
      if (state == S_SCR_RD && !issue) step <= '0;
      if (state == S_SCR_WR && !issue) begin
        step <= '0;
        if (idx != IDX_LAST) idx <= 12'(idx + 12'd1);
      end
    end
  end

endmodule
